// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read RAM port between the CPU MEM
// stage and a debug requester, with starvation-bounded priority for the CPU.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_rvalid,
  input  logic        dbg_req,
  input  logic [3:0]  dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_gnt,
  output logic [31:0] dbg_rdata,
  output logic        dbg_rvalid,
  output logic [3:0]  mem_we,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  owner_e      owner_q, owner_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        cpu_grant, dbg_grant;
  logic        unused_dbg_addr_lo;

  // Debug accesses arrive word-aligned, so their low address bits carry nothing.
  assign unused_dbg_addr_lo = ^dbg_addr[1:0];

  // Move lane-0 aligned byte enables / store data up to the addressed byte lane;
  // lanes pushed past bit 31 fall off the word.
  function automatic logic [3:0] lane_we(input logic [3:0] we, input logic [1:0] ofs);
    return we << ofs;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [31:0] wdata, input logic [1:0] ofs);
    return wdata << {ofs, 3'b000};
  endfunction

  always_comb begin
    dbg_grant    = ~rst & dbg_req & (~cpu_req | (starve_cnt_q == LIMIT));
    cpu_grant    = ~rst & cpu_req & ~dbg_grant;
    mem_we       = 4'b0000;
    mem_addr     = 30'd0;
    mem_wdata    = 32'd0;
    owner_d      = OWN_NONE;
    starve_cnt_d = 4'd0;
    if (dbg_grant) begin
      mem_we    = dbg_we;
      mem_addr  = dbg_addr[31:2];
      mem_wdata = dbg_wdata;
      if (dbg_we == 4'b0000) owner_d = OWN_DBG;
    end else if (cpu_grant) begin
      mem_we    = lane_we(cpu_we, cpu_addr[1:0]);
      mem_addr  = cpu_addr[31:2];
      mem_wdata = lane_wdata(cpu_wdata, cpu_addr[1:0]);
      if (cpu_we == 4'b0000) owner_d = OWN_CPU;
    end
    if (dbg_req && !dbg_grant)
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= 4'd0;
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Read return: one cycle after the grant; a read in flight when reset hits is dropped.
  assign cpu_stall  = cpu_req & ~cpu_grant;
  assign dbg_gnt    = dbg_grant;
  assign cpu_rvalid = ~rst & (owner_q == OWN_CPU);
  assign dbg_rvalid = ~rst & (owner_q == OWN_DBG);
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: lane steering, read return, starvation
// grant, debug writes and reset behaviour.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        cpu_rvalid;
  logic        dbg_req;
  logic [3:0]  dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic [3:0]  mem_we;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  dmem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    dbg_req = 1'b0; dbg_we = 4'h0; dbg_addr = 32'h0; dbg_wdata = 32'h0;
  endtask

  initial begin
    rst = 1'b1;
    mem_rdata = 32'h0;
    idle();
    tick();
    tick();
    #2;
    chk("rst_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rst_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rst_starve", {28'd0, dut.starve_cnt_q}, 32'd0);

    // Requests during reset: no grants, CPU sees a stall.
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h44;
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h80;
    #2;
    chk("rst_cpu_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rst_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {2'd0, mem_addr}, 32'd0);

    tick();
    rst = 1'b0;
    idle();
    // Aligned-lane shift of a halfword store at byte offset 2.
    cpu_req = 1'b1; cpu_we = 4'b0011; cpu_addr = 32'h102; cpu_wdata = 32'h0000BEEF;
    #2;
    chk("st_mem_addr", {2'd0, mem_addr}, 32'h40);
    chk("st_mem_we", {28'd0, mem_we}, 32'hC);
    chk("st_mem_wdata", mem_wdata, 32'hBEEF0000);
    chk("st_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    chk("st_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);

    tick();
    idle();
    #2;
    chk("st_no_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);
    chk("idle_mem_we", {28'd0, mem_we}, 32'd0);
    chk("idle_mem_wdata", mem_wdata, 32'd0);

    // CPU read at 0x200 with one-cycle return.
    cpu_req = 1'b1; cpu_addr = 32'h200;
    #2;
    chk("rd_mem_addr", {2'd0, mem_addr}, 32'h80);
    chk("rd_mem_we", {28'd0, mem_we}, 32'd0);
    tick();
    idle();
    mem_rdata = 32'h12345678;
    #2;
    chk("rd_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd1);
    chk("rd_cpu_rdata", cpu_rdata, 32'h12345678);
    chk("rd_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    tick();
    #2;
    chk("rd_rvalid_once", {31'd0, cpu_rvalid}, 32'd0);

    // Both requesters held: CPU wins four cycles, debug forced on the fifth.
    cpu_req = 1'b1; cpu_we = 4'hF; cpu_addr = 32'h8; cpu_wdata = 32'h11223344;
    dbg_req = 1'b1; dbg_we = 4'h0; dbg_addr = 32'h20;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) mem_rdata = 32'hCAFEF00D;
      #2;
      chk($sformatf("starve_c%0d_dbg_gnt", c), {31'd0, dbg_gnt}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_c%0d_stall", c), {31'd0, cpu_stall}, (c == 4) ? 32'd1 : 32'd0);
      chk($sformatf("starve_c%0d_addr", c), {2'd0, mem_addr}, (c == 4) ? 32'h8 : 32'h2);
      if (c == 5) begin
        chk("starve_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd1);
        chk("starve_dbg_rdata", dbg_rdata, 32'hCAFEF00D);
        chk("starve_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
      end
      tick();
    end

    // Debug-only write.
    idle();
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h10; dbg_wdata = 32'hA5A5A5A5;
    #2;
    chk("dwr_dbg_gnt", {31'd0, dbg_gnt}, 32'd1);
    chk("dwr_mem_addr", {2'd0, mem_addr}, 32'h4);
    chk("dwr_mem_we", {28'd0, mem_we}, 32'hF);
    chk("dwr_mem_wdata", mem_wdata, 32'hA5A5A5A5);
    tick();
    idle();
    #2;
    chk("dwr_no_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);

    // Store at byte offset 3: upper enable and byte fall off the word.
    cpu_req = 1'b1; cpu_we = 4'b0011; cpu_addr = 32'h103; cpu_wdata = 32'h0000BEEF;
    #2;
    chk("ua_mem_we", {28'd0, mem_we}, 32'h8);
    chk("ua_mem_wdata", mem_wdata, 32'hEF000000);
    chk("ua_mem_addr", {2'd0, mem_addr}, 32'h40);
    tick();

    // CPU read granted, then reset asserted: the return is discarded.
    idle();
    cpu_req = 1'b1; cpu_addr = 32'h300;
    dbg_req = 1'b1; dbg_we = 4'hF; dbg_addr = 32'h40;
    #2;
    chk("rr_cpu_grant", {31'd0, cpu_stall}, 32'd0);
    tick();
    rst = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    #2;
    chk("rr_cpu_rvalid", {31'd0, cpu_rvalid}, 32'd0);
    chk("rr_dbg_rvalid", {31'd0, dbg_rvalid}, 32'd0);
    chk("rr_dbg_gnt", {31'd0, dbg_gnt}, 32'd0);
    chk("rr_cpu_stall", {31'd0, cpu_stall}, 32'd1);
    chk("rr_mem_we", {28'd0, mem_we}, 32'd0);
    chk("rr_mem_addr", {2'd0, mem_addr}, 32'd0);
    chk("rr_mem_wdata", mem_wdata, 32'd0);
    tick();
    #2;
    chk("rr_starve", {28'd0, dut.starve_cnt_q}, 32'd0);
    chk("rr_cpu_rvalid2", {31'd0, cpu_rvalid}, 32'd0);
    rst = 1'b0;
    idle();
    tick();
    #2;
    chk("post_rst_rvalid", {30'd0, cpu_rvalid, dbg_rvalid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
